// File: rtl/pool_note_player.sv
// rtl/pool_note_player.sv - draws a uniform random pool index per beat and plays the stored note as a square wave
module pool_note_player #(
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          BEAT_CYCLES = 12_500_000,
    parameter int          POOL_SIZE   = 100,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       enable,
    output logic [6:0] pool_rd_addr,
    input  logic [3:0] pool_rd_data,
    output logic [3:0] note_code,
    output logic       note_valid,
    output logic       speaker
);

    localparam int             BW         = $clog2(BEAT_CYCLES);
    localparam logic [BW-1:0]  BEAT_LAST  = BW'(BEAT_CYCLES - 1);
    localparam logic [7:0]     POOL_LIMIT = 8'(POOL_SIZE);

    // Half-period table for codes 0..15 (C4 upward, equal temperament), packed 20 bits per entry.
    function automatic logic [319:0] build_half_table();
        logic [319:0] t;
        real          f;
        real          h;
        int           v;
        t = '0;
        for (int n = 0; n < 16; n++) begin
            f = 261.63 * (2.0 ** ($itor(n) / 12.0));
            h = $itor(CLK_HZ) / (2.0 * f);
            v = $rtoi(h + 0.5);
            if (v < 1) v = 1;
            if (v > 1048575) v = 1048575;
            t[n*20 +: 20] = v[19:0];
        end
        return t;
    endfunction

    localparam logic [319:0] HALF_TABLE = build_half_table();

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        FETCH,
        LATCH,
        PLAY
    } state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [19:0]   half_cnt;
    logic [BW-1:0] beat_cnt;
    logic [19:0]   half_rom [16];
    logic          is_rest;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            half_rom[i] = HALF_TABLE[i*20 +: 20];
        end
    end

    // Fibonacci feedback from taps 16,14,13,11, shifting toward the MSB.
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign is_rest   = (note_code > 4'd12);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            pool_rd_addr <= 7'd0;
            note_code    <= 4'd15;
            note_valid   <= 1'b0;
            speaker      <= 1'b0;
            half_cnt     <= 20'd0;
            beat_cnt     <= '0;
        end else begin
            note_valid <= (state == LATCH);
            case (state)
                IDLE: begin
                    speaker <= 1'b0;
                    if (enable) begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    lfsr <= lfsr_next;
                    // Rejection sampling keeps the index uniform over the valid entries.
                    if ({1'b0, lfsr_next[6:0]} < POOL_LIMIT) begin
                        pool_rd_addr <= lfsr_next[6:0];
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    note_code <= pool_rd_data;
                    half_cnt  <= half_rom[pool_rd_data];
                    beat_cnt  <= BEAT_LAST;
                    speaker   <= 1'b0;
                    state     <= PLAY;
                end
                PLAY: begin
                    if (half_cnt == 20'd0) begin
                        half_cnt <= half_rom[note_code] - 20'd1;
                        if (!is_rest) begin
                            speaker <= ~speaker;
                        end
                    end else begin
                        half_cnt <= half_cnt - 20'd1;
                    end
                    if (beat_cnt == '0) begin
                        if (enable) begin
                            state <= DRAW;
                        end else begin
                            state   <= IDLE;
                            speaker <= 1'b0;
                        end
                    end else begin
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_note_player.sv
// tb/tb_pool_note_player.sv - self-checking bench for pool_note_player
`timescale 1ns/1ps
module tb_pool_note_player;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [6:0] addr;
    logic [3:0] rd_data;
    logic [3:0] code;
    logic       nv;
    logic       spk;
    logic [3:0] pool [128];

    logic       h_resetn;
    logic [6:0] h_addr;
    logic [3:0] h_rd_data;
    logic [3:0] h_code;
    logic       h_nv;
    logic       h_spk;
    logic [3:0] h_pool [128];

    always #5 clk = ~clk;

    pool_note_player #(
        .CLK_HZ(8800), .BEAT_CYCLES(200), .POOL_SIZE(100), .LFSR_SEED(16'hACE1)
    ) dut (
        .CLOCK_50(clk), .resetn(resetn), .enable(enable), .pool_rd_addr(addr),
        .pool_rd_data(rd_data), .note_code(code), .note_valid(nv), .speaker(spk)
    );

    pool_note_player #(
        .CLK_HZ(8800), .BEAT_CYCLES(2), .POOL_SIZE(100), .LFSR_SEED(16'hACE1)
    ) dut_hist (
        .CLOCK_50(clk), .resetn(h_resetn), .enable(1'b1), .pool_rd_addr(h_addr),
        .pool_rd_data(h_rd_data), .note_code(h_code), .note_valid(h_nv), .speaker(h_spk)
    );

    always @(posedge clk) rd_data   <= pool[addr];
    always @(posedge clk) h_rd_data <= h_pool[h_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int h_hist [16] = '{default: 0};
    int h_count = 0;
    int h_bad = 0;
    always @(negedge clk) begin
        if (h_nv === 1'b1 && h_count < 10000) begin
            h_hist[h_code] <= h_hist[h_code] + 1;
            h_count        <= h_count + 1;
            if (h_addr >= 7'd100) h_bad <= h_bad + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference LFSR: feedback is the parity of the tapped bits (mask 0xB400).
    logic [15:0] m_lfsr;
    task automatic model_next(output int a, output int draws);
        draws = 0;
        do begin
            m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
            draws++;
        end while (m_lfsr[6:0] >= 7'd100 && draws < 1000);
        a = int'(m_lfsr[6:0]);
    endtask

    task automatic wait_note(input string name, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (nv === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: note_valid timeout got 0 expected 1", name);
        end
    endtask

    int  prev_cyc;
    bit  have_prev;

    task automatic note_checks(input string name, input int exp_code, output int draws);
        int a;
        model_next(a, draws);
        check({name, " addr"}, int'(addr), a);
        check({name, " addr_range"}, int'(addr < 7'd100), 1);
        check({name, " code"}, int'(code), exp_code);
        if (have_prev) check({name, " cadence"}, cyc - prev_cyc, 202 + draws);
        prev_cyc  = cyc;
        have_prev = 1'b1;
    endtask

    task automatic count_beat(input int drop_at, output int toggles);
        logic last;
        last    = spk;
        toggles = 0;
        for (int i = 1; i <= 199; i++) begin
            @(negedge clk);
            if (i == drop_at) enable = 1'b0;
            if (spk !== last) toggles++;
            last = spk;
        end
    endtask

    task automatic fill_pool(input logic [3:0] v);
        for (int k = 0; k < 128; k++) pool[k] = v;
    endtask

    typedef struct {
        logic [3:0] fill;
        int         exp_code;
        int         exp_toggles;
    } vec_t;

    vec_t vecs [9];

    initial begin
        bit seen;
        int draws;
        int toggles;
        int first_addr;
        int raise_cyc;
        int bad;
        int exp;
        int diff;

        // Toggles over PLAY cycles 1..199 with half period H: floor(198/H).
        vecs[0] = '{4'd9,  9,  19};
        vecs[1] = '{4'd0,  0,  11};
        vecs[2] = '{4'd12, 12, 24};
        vecs[3] = '{4'd5,  5,  15};
        vecs[4] = '{4'd3,  3,  14};
        vecs[5] = '{4'd7,  7,  18};
        vecs[6] = '{4'd14, 14, 0};
        vecs[7] = '{4'd15, 15, 0};
        vecs[8] = '{4'd13, 13, 0};

        for (int k = 0; k < 128; k++) h_pool[k] = (k < 100) ? 4'(k % 13) : 4'd15;
        fill_pool(4'd9);
        resetn   = 1'b0;
        h_resetn = 1'b0;
        enable   = 1'b0;
        m_lfsr   = 16'hACE1;
        have_prev = 1'b0;
        first_addr = 0;
        repeat (3) @(negedge clk);
        check("reset note_code", int'(code), 15);
        check("reset note_valid", int'(nv), 0);
        check("reset speaker", int'(spk), 0);
        check("reset addr", int'(addr), 0);
        resetn   = 1'b1;
        h_resetn = 1'b1;
        enable   = 1'b1;

        for (int i = 0; i < 9; i++) begin
            fill_pool(vecs[i].fill);
            wait_note($sformatf("vec%0d", i), seen);
            if (seen) begin
                if (i == 0) first_addr = int'(addr);
                note_checks($sformatf("vec%0d", i), vecs[i].exp_code, draws);
                count_beat(0, toggles);
                check($sformatf("vec%0d toggles", i), toggles, vecs[i].exp_toggles);
            end
        end

        // Enable dropped mid-beat: note finishes, then IDLE with speaker low.
        fill_pool(4'd9);
        wait_note("drop", seen);
        if (seen) begin
            note_checks("drop", 9, draws);
            count_beat(50, toggles);
            check("drop toggles", toggles, 19);
            @(negedge clk);
            check("drop idle speaker", int'(spk), 0);
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (nv !== 1'b0 || spk !== 1'b0) bad++;
            end
            check("drop idle quiet", bad, 0);
            enable    = 1'b1;
            raise_cyc = cyc;
            have_prev = 1'b0;
            wait_note("reraise", seen);
            if (seen) begin
                note_checks("reraise", 9, draws);
                check("reraise latency", cyc - raise_cyc, draws + 3);
            end
        end

        // Asynchronous reset while the speaker is high.
        seen = 1'b0;
        for (int i = 0; i < 199 && !seen; i++) begin
            @(negedge clk);
            if (spk === 1'b1) seen = 1'b1;
        end
        check("speaker high before reset", int'(seen), 1);
        #2 resetn = 1'b0;
        #1;
        check("async reset speaker", int'(spk), 0);
        check("async reset note_valid", int'(nv), 0);
        check("async reset note_code", int'(code), 15);
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        m_lfsr    = 16'hACE1;
        have_prev = 1'b0;
        wait_note("after reset", seen);
        if (seen) begin
            note_checks("after reset", 9, draws);
            check("after reset repeats first addr", int'(addr), first_addr);
        end

        // Histogram from the fast-beat instance: codes 0..8 own 8 entries, 9..12 own 7.
        for (int i = 0; i < 90000 && h_count < 10000; i++) @(negedge clk);
        @(negedge clk);
        check("hist note count", h_count, 10000);
        check("hist addr out of range", h_bad, 0);
        check("hist rest codes", h_hist[13] + h_hist[14] + h_hist[15], 0);
        for (int c = 0; c < 13; c++) begin
            exp  = (c < 9) ? 800 : 700;
            diff = h_hist[c] - exp;
            if (diff < 0) diff = -diff;
            checks++;
            if (diff > 150) begin
                failures++;
                $display("FAIL hist code %0d: got %0d expected %0d +/- 150", c, h_hist[c], exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
